// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared frame codes, target codes and loader state encoding
package program_loader_pkg;
  localparam logic [7:0] HDR_LOAD = 8'hA5;
  localparam logic [7:0] HDR_RUN  = 8'h5A;
  localparam logic [7:0] TGT_IMEM = 8'h00;
  localparam logic [7:0] TGT_DMEM = 8'h01;
  typedef enum logic [2:0] {
    S_IDLE, S_TARGET, S_ADDR, S_LEN, S_DATA, S_CHECK, S_ERROR, S_RUN
  } state_t;
endpackage

// File: rtl/program_loader_checksum.sv
// loader_checksum: running XOR accumulator over accepted frame bytes
//   clk, reset (async active-low), clr (zero the sum, wins over en),
//   en (fold din into sum), din[7:0], sum[7:0]
module loader_checksum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] sum
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) sum <= 8'h00;
    else sum <= clr ? 8'h00 : en ? sum ^ din : sum;
endmodule

// File: rtl/program_loader.sv
// program_loader: byte-stream frame loader for the 8-bit processor memories
//   clk, reset (async active-low)
//   in_data/in_valid/in_ready : host byte stream (valid/ready handshake)
//   cpu_hlt in, cpu_hold out  : processor halt status / hold-in-reset control
//   imem_*/dmem_*             : instruction / data memory write ports
//   load_error (sticky), run_done (1-cycle pulse), frame_count (good frames)
module program_loader
  import program_loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       cpu_hlt,
  output logic       cpu_hold,
  output logic       imem_we,
  output logic [7:0] imem_addr,
  output logic [7:0] imem_din,
  output logic       dmem_we,
  output logic [7:0] dmem_addr,
  output logic [7:0] dmem_din,
  output logic       load_error,
  output logic       run_done,
  output logic [7:0] frame_count
);
  state_t     state, next;
  logic       acc, clr, en, wr, good, err_set, err_clr, run_exit;
  logic       tgt, run_armed;
  logic [7:0] addr_cnt, cnt, wr_addr, wr_din, sum;
  assign acc = in_valid && in_ready;
  assign imem_addr = wr_addr;
  assign dmem_addr = wr_addr;
  assign imem_din = wr_din;
  assign dmem_din = wr_din;
  loader_checksum u_sum (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .din(in_data), .sum(sum)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= next;
  always_comb begin
    next = state;
    clr = 1'b0;
    en = 1'b0;
    wr = 1'b0;
    good = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    run_exit = 1'b0;
    case (state)
      S_IDLE:
        if (acc && in_data == HDR_LOAD) begin
          next = S_TARGET;
          clr = 1'b1;
          err_clr = 1'b1;
        end else if (acc && in_data == HDR_RUN) next = S_RUN;
      S_ERROR:
        if (acc && in_data == HDR_LOAD) begin
          next = S_TARGET;
          clr = 1'b1;
          err_clr = 1'b1;
        end
      S_TARGET:
        if (acc) begin
          en = 1'b1;
          err_set = in_data > TGT_DMEM;
          next = err_set ? S_ERROR : S_ADDR;
        end
      S_ADDR:
        if (acc) begin
          en = 1'b1;
          next = S_LEN;
        end
      S_LEN:
        if (acc) begin
          en = 1'b1;
          next = S_DATA;
        end
      // cnt holds bytes remaining mod 256, so a length of 0 runs 256 bytes
      S_DATA:
        if (acc) begin
          en = 1'b1;
          wr = 1'b1;
          next = cnt == 8'd1 ? S_CHECK : S_DATA;
        end
      S_CHECK:
        if (acc) begin
          good = sum == in_data;
          err_set = !good;
          next = S_IDLE;
        end
      // run_armed is low on the first RUN cycle, so RUN lasts at least 2 cycles
      S_RUN:
        if (cpu_hlt && run_armed) begin
          run_exit = 1'b1;
          next = S_IDLE;
        end
      default: next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      in_ready <= 1'b1;
      cpu_hold <= 1'b1;
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      wr_addr <= 8'h00;
      wr_din <= 8'h00;
      load_error <= 1'b0;
      run_done <= 1'b0;
      frame_count <= 8'h00;
      tgt <= 1'b0;
      run_armed <= 1'b0;
      addr_cnt <= 8'h00;
      cnt <= 8'h00;
    end else begin
      in_ready <= next != S_RUN;
      cpu_hold <= next != S_RUN;
      run_armed <= state == S_RUN;
      run_done <= run_exit;
      imem_we <= wr && !tgt;
      dmem_we <= wr && tgt;
      load_error <= err_set ? 1'b1 : err_clr ? 1'b0 : load_error;
      if (good) frame_count <= frame_count + 8'd1;
      if (acc && state == S_TARGET) tgt <= in_data[0];
      if (acc && state == S_ADDR) addr_cnt <= in_data;
      if (acc && state == S_LEN) cnt <= in_data;
      if (wr) begin
        wr_addr <= addr_cnt;
        wr_din <= in_data;
        addr_cnt <= addr_cnt + 8'd1;
        cnt <= cnt - 8'd1;
      end
    end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have these parameters: none; all widths SHALL be fixed at 8-bit data and 8-bit addresses, matching the 8-bit processor memories.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 in_data  input  8  byte from the host stream.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid and in_ready are both 1 on a rising edge.
REQ-007 cpu_hlt  input  1  processor is executing HLT.
REQ-008 cpu_hold  output  1  1 holds the processor in reset; 0 lets it run.
REQ-009 imem_we, imem_addr[7:0], imem_din[7:0]  outputs  instruction-memory write port.
REQ-010 dmem_we, dmem_addr[7:0], dmem_din[7:0]  outputs  data-memory write port.
REQ-011 load_error  output  1  sticky frame-error flag.
REQ-012 run_done  output  1  one-cycle pulse when a run ends on HLT.
REQ-013 frame_count  output  8  number of frames whose checksum matched, wrapping 255->0.

Function
REQ-014 Frame format SHALL be: header 0xA5, target (0x00 = instruction memory, 0x01 = data memory), start address, length L, L payload bytes, checksum.
REQ-015 L = 0x00 SHALL mean 256 payload bytes.
REQ-016 Checksum SHALL be the 8-bit XOR of the target, address, length and all payload bytes.
REQ-017 States SHALL be IDLE, TARGET, ADDR, LEN, DATA, CHECK, ERROR and RUN.
REQ-018 IDLE: on byte 0xA5 the block SHALL go to TARGET; on byte 0x5A it SHALL go to RUN; any other byte SHALL be discarded.
REQ-019 TARGET: a value other than 0x00 or 0x01 SHALL set load_error and go to ERROR; otherwise the block SHALL go to ADDR.
REQ-020 ADDR and LEN SHALL each accept one byte and then advance to the next state.
REQ-021 DATA: each accepted payload byte SHALL produce exactly one write strobe on the selected port, in the cycle after acceptance.
REQ-022 The write address SHALL start at the frame's start address and increment by 1 per byte, wrapping 0xFF->0x00.
REQ-023 CHECK: on a match the block SHALL increment frame_count; on a mismatch it SHALL set load_error; in both cases it SHALL return to IDLE.
REQ-024 Payload already written SHALL NOT be rolled back after a checksum mismatch.
REQ-025 ERROR SHALL discard bytes until it receives 0xA5, then go to TARGET.
REQ-026 load_error SHALL clear when a header 0xA5 is accepted in ERROR or IDLE.
REQ-027 in_ready SHALL be 1 in every state except RUN, where it SHALL be 0.
REQ-028 cpu_hold SHALL be 0 only in RUN.
REQ-029 RUN SHALL last at least 2 cycles.
REQ-030 In RUN, cpu_hlt = 1 SHALL pulse run_done for one cycle, set cpu_hold to 1 and return to IDLE.
REQ-031 imem_we and dmem_we SHALL never both be 1 in the same cycle.
REQ-032 A write enable SHALL never be 1 outside DATA, apart from the single registered cycle that follows it.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 While reset = 0 the block SHALL asynchronously force: state IDLE, cpu_hold = 1, in_ready = 1, imem_we = dmem_we = 0, all addr/din = 0x00, load_error = 0, run_done = 0, frame_count = 0x00.
REQ-035 A reset in any state, including DATA mid-frame or RUN, SHALL abandon the frame and apply REQ-034.
REQ-036 No memory writes SHALL occur after a reset.

Structure
REQ-037 Header/run codes (0xA5, 0x5A), target codes and the state encoding SHALL live in the shared definitions include file alongside the opcode defines.
REQ-038 The block SHALL have one sub-module, loader_checksum: a running XOR accumulator with clear and enable inputs.
REQ-039 The top level SHALL be instantiated above processador_8_bits, driving its reset and the memory write ports.

Verification
REQ-040 Send A5 00 10 03 11 22 33 00 (checksum 00^10^03^11^22^33 = 0x13; use 0x13) -> imem writes 0x10=11, 0x11=22, 0x12=33; frame_count = 1; load_error = 0.
REQ-041 Send A5 01 FE 03 AA BB CC with a wrong checksum 0x00 -> dmem writes 0xFE=AA, 0xFF=BB, 0x00=CC; load_error = 1; frame_count unchanged.
REQ-042 Send A5 07 -> load_error = 1 and state ERROR; then send a valid frame -> load_error clears at A5 and the frame is written normally.
REQ-043 After a valid load, send 5A -> cpu_hold falls and in_ready = 0; drive cpu_hlt = 1 after 20 cycles -> run_done pulses for exactly 1 cycle, cpu_hold = 1 and in_ready = 1.
REQ-044 Assert reset after the second payload byte of a 3-byte frame -> no further writes occur; all outputs take their REQ-034 values.
REQ-045 Send a frame with L = 00 and 256 bytes -> 256 consecutive writes with the address wrapping back to the start address.
